// File: rtl/mux_4to2_sched.sv
// Round-robin scheduler sharing two registered byte lanes among four valid/ready input streams.
// Optional feature macro: MUX_SCHED_RR_EN (defined = round-robin, undefined = fixed priority).
module mux_4to2_sched (
    input  logic       clk_2f,
    input  logic       reset_L,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid_bit0,
    input  logic       valid_bit1,
    input  logic       valid_bit2,
    input  logic       valid_bit3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic       valid_bit_out1,
    output logic       valid_bit_out2
);

    logic [3:0] r_full;
    logic [7:0] r_hold [4];
    logic [1:0] r_ptr;
    logic [7:0] r_data1;
    logic [7:0] r_data2;
    logic       r_vld1;
    logic       r_vld2;

    logic [7:0] w_in [4];
    logic [3:0] w_valid;
    logic [3:0] w_ready;
    logic [3:0] w_accept;
    logic [3:0] w_grant;
    logic [1:0] w_idx [4];
    logic       w_g1;
    logic       w_g2;
    logic [1:0] w_g1_idx;
    logic [1:0] w_g2_idx;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;
    assign w_valid = {valid_bit3, valid_bit2, valid_bit1, valid_bit0};

    // Without round-robin the pointer is never updated, so scanning always starts at input 0.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = r_ptr + 2'(k);
        end
    end

    always_comb begin
        w_g1     = 1'b0;
        w_g2     = 1'b0;
        w_g1_idx = 2'd0;
        w_g2_idx = 2'd0;
        w_grant  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (r_full[w_idx[k]]) begin
                if (!w_g1) begin
                    w_g1     = 1'b1;
                    w_g1_idx = w_idx[k];
                end else if (!w_g2) begin
                    w_g2     = 1'b1;
                    w_g2_idx = w_idx[k];
                end
            end
        end
        if (w_g1) w_grant[w_g1_idx] = 1'b1;
        if (w_g2) w_grant[w_g2_idx] = 1'b1;
    end

    // A granted entry drains this edge, so it can be refilled in the same cycle.
    assign w_ready  = {4{!reset_L}} & (~r_full | w_grant);
    assign w_accept = w_valid & w_ready;

`ifdef MUX_SCHED_RR_EN
    logic [1:0] w_last_idx;
    assign w_last_idx = w_g2 ? w_g2_idx : w_g1_idx;
`endif

    always_ff @(posedge clk_2f) begin
        if (reset_L) begin
            r_full  <= 4'b0000;
            r_ptr   <= 2'd0;
            r_data1 <= 8'h00;
            r_data2 <= 8'h00;
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_accept[i]) begin
                    r_hold[i] <= w_in[i];
                    r_full[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            r_vld1  <= w_g1;
            r_vld2  <= w_g2;
            r_data1 <= w_g1 ? r_hold[w_g1_idx] : 8'h00;
            r_data2 <= w_g2 ? r_hold[w_g2_idx] : 8'h00;
`ifdef MUX_SCHED_RR_EN
            if (w_g1) r_ptr <= w_last_idx + 2'd1;
`endif
        end
    end

    assign ready0         = w_ready[0];
    assign ready1         = w_ready[1];
    assign ready2         = w_ready[2];
    assign ready3         = w_ready[3];
    assign data_out1      = r_data1;
    assign data_out2      = r_data2;
    assign valid_bit_out1 = r_vld1;
    assign valid_bit_out2 = r_vld2;

endmodule

// File: doc/mux_4to2_sched.md
# mux_4to2_sched

Round-robin scheduler that shares the two output lanes of the 4-to-2 byte mux stage among four input streams. It runs in the clk_2f domain of the phy. Each input has a one-entry holding register with a valid/ready handshake. Every cycle the block grants up to two pending inputs to lanes 1 and 2 and drives registered byte and valid outputs, so all four inputs get fair service even when more than two are active.

## Interface
Parameters:
- none; width fixed at 8 bits, 4 inputs, 2 lanes.

Ports:
- clk_2f  in  1  single clock; all state updates on its rising edge.
- reset_L  in  1  synchronous, active-high reset: 1 = reset, sampled on clk_2f rising edge.
- in0, in1, in2, in3  in  8 each  input bytes.
- valid_bit0..valid_bit3  in  1 each  input byte valid.
- ready0..ready3  out  1 each  holding register can accept this cycle.
- data_out1, data_out2  out  8 each  registered lane bytes.
- valid_bit_out1, valid_bit_out2  out  1 each  registered lane valids.

## Operation
- State:
  - full[3:0] and hold0..3[7:0], one holding register per input.
  - 2-bit priority pointer ptr.
  - Output registers for both lanes.
- Accept: input i is captured when valid_bit_i && ready_i at a rising edge.
- Ready: ready_i = !reset_L && (!full_i || grant_i).
  - Combinational from registered state only; it never depends on in*/valid*.
- Grant:
  - Scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) over full[].
  - First full index is granted to lane 1; second full index is granted to lane 2.
  - Zero or one full entry: the missing lanes get no grant.
- Holding register per edge:
  - If granted and a new byte is accepted in the same cycle, hold_i takes the new byte and full_i stays 1.
  - If granted with no accept, full_i goes to 0.
  - If not granted, hold_i and full_i keep their values.
- Output registers:
  - A lane with a grant loads its valid_bit_out with 1 and its data_out with the granted hold byte.
  - A lane without a grant loads valid 0 and data 0x00. Data is never stale.
- Pointer: if at least one grant, ptr <= (last granted index + 1) mod 4; otherwise ptr is unchanged.
- Lane 2 is never granted unless lane 1 is also granted.
- Reset values (on the edge with reset_L=1):
  - full=0000, hold*=0x00, ptr=0.
  - valid_bit_out1/2=0, data_out1/2=0x00.
  - ready0..3 are 0 while reset_L=1.
- Reset mid-operation discards all held bytes; no output is produced for them.

## Timing
- Latency:
  - A byte accepted at edge N is in hold at N.
  - It appears on a lane at edge N+1 if granted, later if blocked.
- Throughput:
  - Up to 2 bytes per cycle in aggregate.
  - One input can sustain 1 byte per cycle while it is granted every cycle, because ready stays 1 through grant+refill.
- Fairness: with all four inputs always full, grants alternate {0,1},{2,3},{0,1}…
  - In RR mode no input waits more than 1 cycle between grants.
- Simultaneous accept and grant on the same input: the old byte goes out and the new byte is stored. No loss, no duplication.
- Empty: with all full=0, both lanes output valid 0 / 0x00 every cycle.

## Configuration
- MUX_SCHED_RR_EN defined: round-robin pointer behaves as above.
- MUX_SCHED_RR_EN undefined:
  - Fixed priority in0 > in1 > in2 > in3; ptr is held at 0.
  - A continuously full in0 and in1 starve in2 and in3 (documented, intended for debug).

## Test plan
- Reset: hold reset_L=1 for 2 cycles with valid_bit0..3=1 → ready0..3=0, outputs 0/0x00, nothing captured after release.
- Single stream: in0=0xA1,0xA2,0xA3 on consecutive cycles, others idle → lane 1 outputs 0xA1,0xA2,0xA3 one cycle after each accept; valid_bit_out2=0 throughout; ready0 stays 1.
- Two streams: in1=0x11 and in3=0x33 accepted on the same edge → next cycle lane 1=0x11, lane 2=0x33, both valids 1.
- Contention (RR): all four inputs valid continuously with in_i=0x10*i+k → lanes give {in0,in1} then {in2,in3} alternately; each ready_i is 1 exactly on its granted cycles; no byte lost or duplicated.
- Pointer wrap: only in3 and in0 full with ptr=3 → lane 1=in3 byte, lane 2=in0 byte, ptr becomes 1.
- Reset mid-run: assert reset_L while full=1111 → after release, no valid output for the discarded bytes; a first new accept on in2=0x5A appears on lane 1.
